grid_mem_piece_placer_top: RTL and testbench
============================================

GRID_MEM_PIECE_PLACER_TOP -- requirements
Module: grid_mem_piece_placer

Interface
REQ-001 SHALL have parameter PIECE_BASE_ADDR, default 240, first address of the 3x4 piece staging area.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port grid_rst  input  1  synchronous active-high reset; clears the memory and piece selector.
REQ-005 SHALL have port placer_rst  input  1  synchronous active-high reset; resets only the placer FSM and outputs.
REQ-006 SHALL have port en  input  1  start placement request.
REQ-007 SHALL have port read_addr  input  8  memory port-B read address.
REQ-008 SHALL have port placed  output  1  placement complete.
REQ-009 SHALL have port we  output  1  placer write strobe, also memory port-A write enable.
REQ-010 SHALL have port write_addr  output  8  placer write address, also memory port-A address.
REQ-011 SHALL have port data  output  8  placer write data.
REQ-012 SHALL have port out_a  output  8  port-A registered read data.
REQ-013 SHALL have port out_b  output  8  port-B registered read data.
REQ-014 SHALL have ports reg_1, reg_2, reg_3, reg_4  output  8 each  addresses of the four piece blocks, ascending.

Function
REQ-015 Memory SHALL be 256x8, dual-port: port A does write plus read, port B does read only.
REQ-016 Port-A write: on posedge with we=1, mem[write_addr] <= data.
REQ-017 Read latency: out_a and out_b SHALL be registered, 1 cycle.
REQ-018 Same-address write and read SHALL return the old data (read-before-write).
REQ-019 Grid cells 0-239 SHALL be untouched by the placer.
REQ-020 Staging cell k (k=0..11, row=k/3, col=k%3) SHALL be at address PIECE_BASE_ADDR+k; addresses 252-255 SHALL never be written.
REQ-021 Piece selector: 3-bit LFSR, next = {s[1:0], s[2]^s[1]}, states 1..7, never 0.
REQ-022 Piece selector sequence from 001 SHALL be 001, 010, 101, 011, 111, 110, 100, 001.
REQ-023 Piece type SHALL equal the selector value and SHALL be the write color; cell sets: 1=I {1,4,7,10}, 2=O {0,1,3,4}, 3=T {0,1,2,4}, 4=S {1,2,3,4}, 5=Z {0,1,4,5}, 6=L {0,3,6,7}, 7=J {1,4,6,7}.
REQ-024 Placer FSM SHALL have states IDLE, WRITE, DONE.
REQ-025 IDLE: we=0; en=1 sampled at a rising edge SHALL move to WRITE with idx=0.
REQ-026 WRITE: each cycle we=1, write_addr=PIECE_BASE_ADDR+idx, data=color if idx is in the cell set, else 0; idx increments.
REQ-027 After idx=11, WRITE SHALL move to DONE; exactly 12 writes, covering all 12 staging cells.
REQ-028 Once WRITE is entered, en SHALL be ignored; deasserting en mid-WRITE does not abort.
REQ-029 DONE: placed=1, we=0, reg_1..reg_4 = PIECE_BASE_ADDR + the four cell indices, ascending.
REQ-030 DONE SHALL be held until placer_rst; en has no effect in DONE.
REQ-031 Selector SHALL advance exactly once, on the WRITE->DONE transition.
REQ-032 Timing: en high at edge 0 gives writes on edges 1-12; placed SHALL rise on the cycle after edge 12 (within 14 cycles of en).
REQ-033 placer_rst mid-WRITE SHALL return the FSM to IDLE; cells already written keep their values; the selector does not advance.
REQ-034 grid_rst and a port-A write in the same cycle: grid_rst SHALL win.

Reset
REQ-035 grid_rst SHALL clear all 256 memory words to 0, set out_a=out_b=0 and set the selector to 001.
REQ-036 placer_rst SHALL set state=IDLE and placed=we=0, write_addr=data=0, reg_1..reg_4=0; it SHALL NOT affect the memory or the selector.
REQ-037 Both resets asserted together SHALL apply both effects.

Verification
REQ-038 Scenario: grid_rst then read 0-255 on port B -> every out_b = 0, one cycle after the address.
REQ-039 Scenario: after grid_rst, en=1 -> 12 writes to 240-251, data 1 at 241/244/247/250 and 0 elsewhere; placed=1; reg_1..4 = 241, 244, 247, 250.
REQ-040 Scenario: placer_rst then en again -> O piece, 2 at 240/241/243/244; then Z (5 at 240/241/244/245), then T (3 at 240/241/242/244).
REQ-041 Scenario: 7 consecutive placements -> types 1, 2, 5, 3, 7, 6, 4, then 1 again; 252-255 and 0-239 remain 0.
REQ-042 Scenario: placer_rst asserted at WRITE idx=5 -> placed stays 0, we=0 next cycle; the next placement uses the same piece type.
REQ-043 Scenario: en held high through DONE for 10 cycles -> no further writes; placed stays 1 until placer_rst.

Source files
------------

// File: rtl/grid_mem_piece_placer_top.sv
// 256x8 dual-port grid memory plus an FSM that stamps a 3x4 piece into a staging area.
// Latency: the reads on both ports are registered and return data 1 cycle after the address. Writes land 1-12 edges after en. placed rises after edge 12.
// Backpressure: none. Once started, a placement runs to completion unless placer_rst aborts it.
module grid_mem_piece_placer_top #(
  parameter int PIECE_BASE_ADDR = 240
) (
  input  logic       clk,
  input  logic       grid_rst,
  input  logic       placer_rst,
  input  logic       en,
  input  logic [7:0] read_addr,
  output logic       placed,
  output logic       we,
  output logic [7:0] write_addr,
  output logic [7:0] data,
  output logic [7:0] out_a,
  output logic [7:0] out_b,
  output logic [7:0] reg_1,
  output logic [7:0] reg_2,
  output logic [7:0] reg_3,
  output logic [7:0] reg_4
);

  localparam logic [7:0] BASE = PIECE_BASE_ADDR[7:0];
  localparam logic [3:0] LAST_IDX = 4'd11;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] sel_q;
  logic       advance;
  logic [7:0] mem [256];

  logic       placed_d, we_d;
  logic [7:0] addr_d, data_d, r1_d, r2_d, r3_d, r4_d;
  logic [15:0] cells;
  logic [7:0]  color;

  // Four ascending cell indices of each piece, packed MSB-first.
  function automatic logic [15:0] piece_cells(input logic [2:0] t);
    case (t)
      3'd1:    piece_cells = {4'd1, 4'd4, 4'd7, 4'd10};
      3'd2:    piece_cells = {4'd0, 4'd1, 4'd3, 4'd4};
      3'd3:    piece_cells = {4'd0, 4'd1, 4'd2, 4'd4};
      3'd4:    piece_cells = {4'd1, 4'd2, 4'd3, 4'd4};
      3'd5:    piece_cells = {4'd0, 4'd1, 4'd4, 4'd5};
      3'd6:    piece_cells = {4'd0, 4'd3, 4'd6, 4'd7};
      3'd7:    piece_cells = {4'd1, 4'd4, 4'd6, 4'd7};
      default: piece_cells = 16'hFFFF;
    endcase
  endfunction

  function automatic logic in_piece(input logic [15:0] c, input logic [3:0] i);
    in_piece = (c[15:12] == i) || (c[11:8] == i) || (c[7:4] == i) || (c[3:0] == i);
  endfunction

  assign cells = piece_cells(sel_q);
  assign color = {5'd0, sel_q};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    placed_d = placed;
    we_d     = we;
    addr_d   = write_addr;
    data_d   = data;
    r1_d     = reg_1;
    r2_d     = reg_2;
    r3_d     = reg_3;
    r4_d     = reg_4;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (en) begin
          state_d = WRITE;
          idx_d   = 4'd0;
          we_d    = 1'b1;
          addr_d  = BASE;
          data_d  = in_piece(cells, 4'd0) ? color : 8'd0;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          we_d     = 1'b0;
          addr_d   = 8'd0;
          data_d   = 8'd0;
          placed_d = 1'b1;
          r1_d     = BASE + {4'd0, cells[15:12]};
          r2_d     = BASE + {4'd0, cells[11:8]};
          r3_d     = BASE + {4'd0, cells[7:4]};
          r4_d     = BASE + {4'd0, cells[3:0]};
          advance  = 1'b1;
        end else begin
          idx_d  = idx_q + 4'd1;
          addr_d = BASE + {4'd0, idx_d};
          data_d = in_piece(cells, idx_d) ? color : 8'd0;
        end
      end
      DONE: begin
        we_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (placer_rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      placed     <= 1'b0;
      we         <= 1'b0;
      write_addr <= 8'd0;
      data       <= 8'd0;
      reg_1      <= 8'd0;
      reg_2      <= 8'd0;
      reg_3      <= 8'd0;
      reg_4      <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      placed     <= placed_d;
      we         <= we_d;
      write_addr <= addr_d;
      data       <= data_d;
      reg_1      <= r1_d;
      reg_2      <= r2_d;
      reg_3      <= r3_d;
      reg_4      <= r4_d;
    end
  end

  // Selector steps only when a placement completes; an aborted placement keeps its piece.
  always_ff @(posedge clk) begin
    if (grid_rst) begin
      sel_q <= 3'b001;
    end else if (advance && !placer_rst) begin
      sel_q <= {sel_q[1:0], sel_q[2] ^ sel_q[1]};
    end
  end

  // Nonblocking reads sample the pre-write word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (grid_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
      out_a <= 8'd0;
      out_b <= 8'd0;
    end else begin
      if (we) mem[write_addr] <= data;
      out_a <= mem[write_addr];
      out_b <= mem[read_addr];
    end
  end

endmodule

// File: tb/tb_grid_mem_piece_placer_top.sv
// Directed sequence with randomized en drops and read addresses, checked against a
// cell-mask reference model of the grid memory and piece order.
module tb_grid_mem_piece_placer_top;

  logic       clk = 1'b0;
  logic       grid_rst, placer_rst, en;
  logic [7:0] read_addr;
  logic       placed, we;
  logic [7:0] write_addr, data, out_a, out_b, reg_1, reg_2, reg_3, reg_4;

  grid_mem_piece_placer_top #(.PIECE_BASE_ADDR(240)) dut (
    .clk(clk), .grid_rst(grid_rst), .placer_rst(placer_rst), .en(en),
    .read_addr(read_addr), .placed(placed), .we(we), .write_addr(write_addr),
    .data(data), .out_a(out_a), .out_b(out_b),
    .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3), .reg_4(reg_4)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         fails = 0;
  logic [7:0] mdl [256];
  logic [11:0] mask [8];
  int         order [7];
  int         type_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a);
    read_addr = a[7:0];
    step();
    chk($sformatf("out_b[%0d]", a), {24'd0, out_b}, {24'd0, mdl[a]});
  endtask

  task automatic scan_staging();
    for (int a = 240; a < 256; a++) rd(a);
  endtask

  // One full placement; optionally drops en partway to show it is ignored.
  task automatic place(input bit drop_en);
    int t;
    int drop_at;
    int n;
    logic [7:0] old [12];
    logic [7:0] exp_reg [4];
    t = order[type_ptr];
    drop_at = $urandom_range(0, 11);
    for (int k = 0; k < 12; k++) old[k] = mdl[240 + k];
    en = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      if (drop_en && k == drop_at) en = 1'b0;
      chk($sformatf("we t%0d k%0d", t, k), {31'd0, we}, 32'd1);
      chk($sformatf("write_addr t%0d k%0d", t, k), {24'd0, write_addr}, 240 + k);
      chk($sformatf("data t%0d k%0d", t, k), {24'd0, data}, mask[t][k] ? t : 0);
      chk($sformatf("placed_low t%0d k%0d", t, k), {31'd0, placed}, 32'd0);
      if (k > 0) chk($sformatf("out_a_rbw t%0d k%0d", t, k), {24'd0, out_a}, {24'd0, old[k-1]});
      step();
    end
    en = 1'b0;
    chk($sformatf("placed t%0d", t), {31'd0, placed}, 32'd1);
    chk($sformatf("we_done t%0d", t), {31'd0, we}, 32'd0);
    chk($sformatf("out_a_rbw t%0d k11", t), {24'd0, out_a}, {24'd0, old[11]});
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (mask[t][k]) begin
        exp_reg[n] = 8'(240 + k);
        n++;
      end
    end
    chk($sformatf("reg_1 t%0d", t), {24'd0, reg_1}, {24'd0, exp_reg[0]});
    chk($sformatf("reg_2 t%0d", t), {24'd0, reg_2}, {24'd0, exp_reg[1]});
    chk($sformatf("reg_3 t%0d", t), {24'd0, reg_3}, {24'd0, exp_reg[2]});
    chk($sformatf("reg_4 t%0d", t), {24'd0, reg_4}, {24'd0, exp_reg[3]});
    for (int k = 0; k < 12; k++) mdl[240 + k] = mask[t][k] ? 8'(t) : 8'd0;
    type_ptr = (type_ptr + 1) % 7;
  endtask

  task automatic pulse_placer_rst();
    placer_rst = 1'b1;
    step();
    placer_rst = 1'b0;
    chk("placed_after_prst", {31'd0, placed}, 32'd0);
    chk("reg_1_after_prst", {24'd0, reg_1}, 32'd0);
  endtask

  initial begin
    mask[0] = 12'h000; mask[1] = 12'h492; mask[2] = 12'h01B; mask[3] = 12'h017;
    mask[4] = 12'h01E; mask[5] = 12'h033; mask[6] = 12'h0C9; mask[7] = 12'h0D2;
    order[0] = 1; order[1] = 2; order[2] = 5; order[3] = 3;
    order[4] = 7; order[5] = 6; order[6] = 4;
    type_ptr = 0;
    for (int a = 0; a < 256; a++) mdl[a] = 8'd0;

    grid_rst = 1'b1; placer_rst = 1'b1; en = 1'b0; read_addr = 8'd0;
    step();
    step();
    chk("rst placed", {31'd0, placed}, 32'd0);
    chk("rst we", {31'd0, we}, 32'd0);
    chk("rst write_addr", {24'd0, write_addr}, 32'd0);
    chk("rst data", {24'd0, data}, 32'd0);
    chk("rst reg_1", {24'd0, reg_1}, 32'd0);
    chk("rst reg_4", {24'd0, reg_4}, 32'd0);
    chk("rst out_a", {24'd0, out_a}, 32'd0);
    chk("rst out_b", {24'd0, out_b}, 32'd0);
    grid_rst = 1'b0; placer_rst = 1'b0;

    for (int a = 0; a < 256; a++) rd(a);

    place(1'b0);
    scan_staging();

    // en held high in DONE must not restart the placer
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("done_hold placed c%0d", c), {31'd0, placed}, 32'd1);
      chk($sformatf("done_hold we c%0d", c), {31'd0, we}, 32'd0);
    end
    en = 1'b0;
    pulse_placer_rst();

    for (int p = 0; p < 7; p++) begin
      place(1'($urandom_range(0, 1)));
      scan_staging();
      for (int r = 0; r < 6; r++) rd($urandom_range(0, 239));
      pulse_placer_rst();
    end

    // Abort at idx 5: cells 0..5 are written, selector stays put
    begin
      int t;
      t = order[type_ptr];
      en = 1'b1;
      step();
      en = 1'b0;
      for (int c = 0; c < 5; c++) step();
      chk("abort write_addr", {24'd0, write_addr}, 32'd245);
      placer_rst = 1'b1;
      step();
      placer_rst = 1'b0;
      chk("abort placed", {31'd0, placed}, 32'd0);
      chk("abort we", {31'd0, we}, 32'd0);
      for (int k = 0; k < 6; k++) mdl[240 + k] = mask[t][k] ? 8'(t) : 8'd0;
      for (int c = 0; c < 3; c++) begin
        step();
        chk($sformatf("abort idle we c%0d", c), {31'd0, we}, 32'd0);
      end
    end
    place(1'b0);
    scan_staging();
    pulse_placer_rst();

    // Both resets while a write is in flight: memory and selector clear, write is lost
    en = 1'b1;
    step();
    en = 1'b0;
    step();
    step();
    grid_rst = 1'b1; placer_rst = 1'b1;
    step();
    grid_rst = 1'b0; placer_rst = 1'b0;
    for (int a = 0; a < 256; a++) mdl[a] = 8'd0;
    type_ptr = 0;
    chk("both_rst placed", {31'd0, placed}, 32'd0);
    chk("both_rst out_a", {24'd0, out_a}, 32'd0);
    for (int a = 0; a < 256; a++) rd(a);
    place(1'b1);
    scan_staging();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
